// File: rtl/dma_engineer_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dma_engineer_arbiter                                          |
// | Description : Round-robin arbiter sharing one DMA read engine among N_REQ   |
// |               layer controllers. Latches the winner's address/length,       |
// |               returns a zero-latency ack and routes beat strobes to the     |
// |               granted layer only. Read data is broadcast to all layers.     |
// | Options     : DMA_ARB_LEN_CHECK_EN - builds a beat counter that raises the  |
// |               sticky err_len flag when the eop beat count differs from the  |
// |               latched length. Undefined: err_len is tied to 0.              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module dma_engineer_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 27,
  parameter int DATA_W = 512,
  parameter int IDX_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        lyr_req,
  input  logic [N_REQ*ADDR_W-1:0] lyr_start_addr,
  input  logic [N_REQ*ADDR_W-1:0] lyr_length,
  output logic [N_REQ-1:0]        lyr_ack,
  output logic [N_REQ-1:0]        lyr_dout_en,
  output logic [N_REQ-1:0]        lyr_dout_eop,
  output logic [DATA_W-1:0]       lyr_dout,
  output logic                    dma_engineer_req,
  input  logic                    dma_engineer_ack,
  output logic [ADDR_W-1:0]       dma_engineer_start_addr,
  output logic [ADDR_W-1:0]       dma_engineer_length,
  input  logic                    dma_engineer_dout_en,
  input  logic                    dma_engineer_dout_eop,
  input  logic [DATA_W-1:0]       dma_engineer_dout,
  output logic                    err_len,
  output logic                    busy
);

  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;

  logic [ADDR_W-1:0] w_addr_arr [N_REQ];
  logic [ADDR_W-1:0] w_len_arr  [N_REQ];

  logic              w_active;
  logic              w_ack_fire;
  logic              w_beat;
  logic              w_last;
  logic              w_found;
  logic [IDX_W-1:0]  w_winner;
  logic [IDX_W-1:0]  w_rr_next;

  // Split the packed per-layer address/length buses into indexable arrays.
  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign w_addr_arr[i] = lyr_start_addr[i*ADDR_W +: ADDR_W];
      assign w_len_arr[i]  = lyr_length[i*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Beats are only honoured while a transaction owns the engine; stray ones in IDLE vanish.
  assign w_active   = (state_q != ST_IDLE);
  assign w_ack_fire = (state_q == ST_REQ) && dma_engineer_ack;
  assign w_beat     = w_active && dma_engineer_dout_en;
  assign w_last     = w_beat && dma_engineer_dout_eop;
  assign w_rr_next  = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  // Round-robin search: first set request at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    logic [SUM_W-1:0] idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (idx >= SUM_W'(N_REQ)) begin
        idx = idx - SUM_W'(N_REQ);
      end
      if (!w_found && lyr_req[idx[IDX_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = idx[IDX_W-1:0];
      end
    end
  end

  // Per-layer ack and beat strobes: one-hot on the current grant.
  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_route
      assign lyr_ack[i]      = w_ack_fire && (grant_q == IDX_W'(i));
      assign lyr_dout_en[i]  = w_beat && (grant_q == IDX_W'(i));
      assign lyr_dout_eop[i] = w_last && (grant_q == IDX_W'(i));
    end
  endgenerate

  // Next-state logic for the grant FSM and its latched request fields.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    req_d    = req_q;
    addr_d   = addr_q;
    len_d    = len_q;
    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          grant_d = w_winner;
          addr_d  = w_addr_arr[w_winner];
          len_d   = w_len_arr[w_winner];
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dma_engineer_ack) begin
          req_d = 1'b0;
          // A single-beat burst may finish in the very cycle it is accepted.
          if (w_last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = w_rr_next;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (w_last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = w_rr_next;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM and latched request registers; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
    end
  end

`ifdef DMA_ARB_LEN_CHECK_EN
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;

  // Count routed beats of the current burst and flag an eop that disagrees with the length.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if ((state_q == ST_IDLE) && w_found) begin
      cnt_d = '0;
    end else if (w_beat) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
    if (w_last && ((cnt_q + ADDR_W'(1)) != len_q)) begin
      err_d = 1'b1;
    end
  end

  // Beat counter and sticky length-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_len = err_q;
`else
  assign err_len = 1'b0;
`endif

  assign lyr_dout                = dma_engineer_dout;
  assign dma_engineer_req        = req_q;
  assign dma_engineer_start_addr = addr_q;
  assign dma_engineer_length     = len_q;
  assign busy                    = w_active;

endmodule
`default_nettype wire

// File: tb/tb_dma_engineer_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dma_engineer_arbiter                                       |
// | Description : Directed self-checking bench for dma_engineer_arbiter.        |
// |               Honours DMA_ARB_LEN_CHECK_EN for the err_len expectation.     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dma_engineer_arbiter;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 512;
  localparam int IDX_W  = 2;
`ifdef DMA_ARB_LEN_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_REQ-1:0]        lyr_req = '0;
  logic [N_REQ*ADDR_W-1:0] lyr_start_addr = '0;
  logic [N_REQ*ADDR_W-1:0] lyr_length = '0;
  logic [N_REQ-1:0]        lyr_ack;
  logic [N_REQ-1:0]        lyr_dout_en;
  logic [N_REQ-1:0]        lyr_dout_eop;
  logic [DATA_W-1:0]       lyr_dout;
  logic                    dma_engineer_req;
  logic                    dma_engineer_ack = 1'b0;
  logic [ADDR_W-1:0]       dma_engineer_start_addr;
  logic [ADDR_W-1:0]       dma_engineer_length;
  logic                    dma_engineer_dout_en = 1'b0;
  logic                    dma_engineer_dout_eop = 1'b0;
  logic [DATA_W-1:0]       dma_engineer_dout = '0;
  logic                    err_len;
  logic                    busy;

  int n_chk = 0;
  int n_err = 0;
  int beat_cnt = 0;
  logic [ADDR_W-1:0] exp_addr [N_REQ];
  logic [ADDR_W-1:0] exp_len  [N_REQ];

  dma_engineer_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)
  ) u_dut (
    .clk(clk), .rst(rst),
    .lyr_req(lyr_req), .lyr_start_addr(lyr_start_addr), .lyr_length(lyr_length),
    .lyr_ack(lyr_ack), .lyr_dout_en(lyr_dout_en), .lyr_dout_eop(lyr_dout_eop),
    .lyr_dout(lyr_dout),
    .dma_engineer_req(dma_engineer_req), .dma_engineer_ack(dma_engineer_ack),
    .dma_engineer_start_addr(dma_engineer_start_addr),
    .dma_engineer_length(dma_engineer_length),
    .dma_engineer_dout_en(dma_engineer_dout_en),
    .dma_engineer_dout_eop(dma_engineer_dout_eop),
    .dma_engineer_dout(dma_engineer_dout),
    .err_len(err_len), .busy(busy)
  );

  always #5 clk = ~clk;

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_layer(input int i, input logic [ADDR_W-1:0] a,
                           input logic [ADDR_W-1:0] l);
    lyr_start_addr[i*ADDR_W +: ADDR_W] = a;
    lyr_length[i*ADDR_W +: ADDR_W]     = l;
    exp_addr[i] = a;
    exp_len[i]  = l;
  endtask

  // Entered at posedge+1 of the first REQ cycle; leaves at posedge+1 after the idle gap cycle.
  task automatic run_txn(input int layer, input int nbeats, input int ack_dly,
                         input logic [N_REQ-1:0] drop);
    logic [N_REQ-1:0]  oh;
    logic [DATA_W-1:0] d;
    oh = N_REQ'(1) << layer;
    for (int c = 0; c < ack_dly; c++) begin
      @(negedge clk);
      check_eq("wait_req", dma_engineer_req, 1'b1);
      check_eq("wait_ack", lyr_ack, '0);
      step();
    end
    dma_engineer_ack = 1'b1;
    @(negedge clk);
    check_eq("ack_req", dma_engineer_req, 1'b1);
    check_eq("ack_vec", lyr_ack, oh);
    check_eq("addr", dma_engineer_start_addr, exp_addr[layer]);
    check_eq("len", dma_engineer_length, exp_len[layer]);
    step();
    dma_engineer_ack = 1'b0;
    lyr_req = lyr_req & ~drop;
    for (int b = 0; b < nbeats; b++) begin
      d = {16{32'hA5A5_0000 | 32'(b * 16 + layer)}};
      dma_engineer_dout_en  = 1'b1;
      dma_engineer_dout_eop = (b == nbeats - 1);
      dma_engineer_dout     = d;
      @(negedge clk);
      check_eq("beat_en", lyr_dout_en, oh);
      check_eq("beat_eop", lyr_dout_eop, (b == nbeats - 1) ? oh : '0);
      check_eq("beat_data", lyr_dout, d);
      if (b == 0) begin
        check_eq("req_drop", dma_engineer_req, 1'b0);
        check_eq("ack_once", lyr_ack, '0);
      end
      if (lyr_dout_en[layer]) beat_cnt++;
      step();
    end
    dma_engineer_dout_en  = 1'b0;
    dma_engineer_dout_eop = 1'b0;
    @(negedge clk);
    check_eq("gap_busy", busy, 1'b0);
    check_eq("gap_req", dma_engineer_req, 1'b0);
    step();
  endtask

  initial begin
    // Reset state.
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_req", dma_engineer_req, 1'b0);
    check_eq("rst_addr", dma_engineer_start_addr, '0);
    check_eq("rst_len", dma_engineer_length, '0);
    check_eq("rst_err", err_len, 1'b0);
    check_eq("rst_ack", lyr_ack, '0);
    step();

    // Single requester on layer 2, ack in the third REQ cycle, 4 beats.
    set_layer(2, 27'd4548, 27'd4);
    lyr_req = 4'b0100;
    @(negedge clk);
    check_eq("t1_idle_req", dma_engineer_req, 1'b0);
    step();
    beat_cnt = 0;
    run_txn(2, 4, 2, 4'b0100);
    check_eq("t1_beats", beat_cnt, 4);
    check_eq("t1_err", err_len, 1'b0);

    // Round robin from a fresh pointer: 0,1,2,3,0 with one idle cycle between.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_layer(i, ADDR_W'(100 * i + 16), 27'd2);
    lyr_req = 4'b1111;
    step();
    run_txn(0, 2, 1, 4'b0000);
    run_txn(1, 2, 1, 4'b0000);
    run_txn(2, 2, 1, 4'b0000);
    run_txn(3, 2, 1, 4'b0000);
    run_txn(0, 2, 1, 4'b1111);

    // Eop in the ack cycle on layer 2 (pointer now 1), request kept high.
    set_layer(2, 27'd777, 27'd1);
    lyr_req = 4'b0100;
    step();
    dma_engineer_ack = 1'b1; dma_engineer_dout_en = 1'b1; dma_engineer_dout_eop = 1'b1;
    @(negedge clk);
    check_eq("t3_ack", lyr_ack, 4'b0100);
    check_eq("t3_en", lyr_dout_en, 4'b0100);
    check_eq("t3_eop", lyr_dout_eop, 4'b0100);
    step();
    dma_engineer_ack = 1'b0; dma_engineer_dout_en = 1'b0; dma_engineer_dout_eop = 1'b0;
    @(negedge clk);
    check_eq("t3_idle", busy, 1'b0);
    check_eq("t3_idle_req", dma_engineer_req, 1'b0);
    step();
    dma_engineer_ack = 1'b1; dma_engineer_dout_en = 1'b1; dma_engineer_dout_eop = 1'b1;
    lyr_req = 4'b0000;
    @(negedge clk);
    check_eq("t3_regrant", dma_engineer_req, 1'b1);
    check_eq("t3_reack", lyr_ack, 4'b0100);
    step();
    dma_engineer_ack = 1'b0; dma_engineer_dout_en = 1'b0; dma_engineer_dout_eop = 1'b0;
    @(negedge clk);
    check_eq("t3_done", busy, 1'b0);
    check_eq("t3_err", err_len, 1'b0);
    step();

    // Stray beat while idle.
    dma_engineer_dout_en = 1'b1; dma_engineer_dout_eop = 1'b1;
    dma_engineer_dout = {16{32'hDEAD_BEEF}};
    @(negedge clk);
    check_eq("t4_en", lyr_dout_en, '0);
    check_eq("t4_eop", lyr_dout_eop, '0);
    check_eq("t4_data", lyr_dout, {16{32'hDEAD_BEEF}});
    step();
    dma_engineer_dout_en = 1'b0; dma_engineer_dout_eop = 1'b0;
    @(negedge clk);
    check_eq("t4_busy", busy, 1'b0);
    step();

    // Reset after 2 of 4 beats on layer 1 (pointer now 3).
    set_layer(1, 27'd2000, 27'd4);
    lyr_req = 4'b0010;
    step();
    dma_engineer_ack = 1'b1;
    @(negedge clk);
    check_eq("t5_ack", lyr_ack, 4'b0010);
    step();
    dma_engineer_ack = 1'b0;
    lyr_req = 4'b0000;
    for (int b = 0; b < 2; b++) begin
      dma_engineer_dout_en = 1'b1;
      @(negedge clk);
      check_eq("t5_beat", lyr_dout_en, 4'b0010);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    dma_engineer_dout_eop = 1'b1;
    @(negedge clk);
    check_eq("t5_busy", busy, 1'b0);
    check_eq("t5_req", dma_engineer_req, 1'b0);
    check_eq("t5_addr", dma_engineer_start_addr, '0);
    check_eq("t5_len", dma_engineer_length, '0);
    check_eq("t5_err", err_len, 1'b0);
    check_eq("t5_en", lyr_dout_en, '0);
    check_eq("t5_eop", lyr_dout_eop, '0);
    check_eq("t5_ackz", lyr_ack, '0);
    step();
    dma_engineer_dout_en = 1'b0; dma_engineer_dout_eop = 1'b0;
    @(negedge clk);
    check_eq("t5_drop", busy, 1'b0);
    step();
    set_layer(0, 27'd3000, 27'd2);
    set_layer(3, 27'd3333, 27'd2);
    lyr_req = 4'b1001;
    step();
    run_txn(0, 2, 0, 4'b0001);
    run_txn(3, 2, 0, 4'b1000);

    // Short burst: length 4 but eop on beat 3.
    set_layer(1, 27'd5000, 27'd4);
    lyr_req = 4'b0010;
    step();
    run_txn(1, 3, 0, 4'b0010);
    @(negedge clk);
    check_eq("t6_err", err_len, EXP_ERR);
    step();
    step();
    @(negedge clk);
    check_eq("t6_hold", err_len, EXP_ERR);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_clr", err_len, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_engineer_arbiter.md
# dma_engineer_arbiter

Shares one DMA read engine among `N_REQ` layer controllers, each of which fetches weights with a req/ack + start_addr/length handshake followed by a burst of 512-bit beats ending in eop. The block sits between the per-layer controllers and the single DMA engine. It grants one requester at a time in round-robin order, forwards that requester's address and length, and routes the returned beat strobes only to the granted layer. Read data is broadcast to every layer.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesting layers (2..8).
- `ADDR_W`, default 27: width of start_addr and length.
- `DATA_W`, default 512: DMA data width.
- `IDX_W`, default 2: grant index width, equal to clog2(N_REQ).

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `lyr_req`, input, N_REQ: per-layer request. Held high until that layer's ack.
- `lyr_start_addr`, input, N_REQ*ADDR_W: packed addresses. Slice i belongs to layer i. Stable while lyr_req[i] is high.
- `lyr_length`, input, N_REQ*ADDR_W: packed burst lengths in beats. Stable while lyr_req[i] is high.
- `lyr_ack`, output, N_REQ: one-cycle ack to the granted layer.
- `lyr_dout_en`, output, N_REQ: per-layer beat valid.
- `lyr_dout_eop`, output, N_REQ: per-layer last beat.
- `lyr_dout`, output, DATA_W: broadcast copy of dma_engineer_dout.
- `dma_engineer_req`, output, 1: request to the DMA engine.
- `dma_engineer_ack`, input, 1: one-cycle acceptance from the DMA engine.
- `dma_engineer_start_addr`, output, ADDR_W: latched address of the winner.
- `dma_engineer_length`, output, ADDR_W: latched length of the winner.
- `dma_engineer_dout_en`, input, 1: beat valid from the DMA engine.
- `dma_engineer_dout_eop`, input, 1: last beat, qualified by dout_en.
- `dma_engineer_dout`, input, DATA_W: beat data.
- `err_len`, output, 1: sticky beat-count mismatch flag (see Configuration).
- `busy`, output, 1: high whenever state is not IDLE.

## Operation
- States: IDLE, REQ, STREAM.
- IDLE:
  - If any lyr_req bit is set, pick the winner by round-robin, starting the search at `rr_ptr`.
  - Register the winner's index into `grant`, and register its addr/length onto the dma_engineer_* outputs.
  - Go to REQ.
- REQ:
  - dma_engineer_req is high.
  - When dma_engineer_ack=1: lyr_ack[grant] = 1 combinationally in that same cycle, and dma_engineer_req drops on the next edge.
  - If dout_en & dout_eop are also set in the ack cycle, go directly to IDLE. Otherwise go to STREAM.
- STREAM:
  - On dout_en & dout_eop, go to IDLE and set rr_ptr = (grant+1) mod N_REQ.
- Routing, in REQ and STREAM:
  - lyr_dout_en[i] = dma_engineer_dout_en & (i==grant); lyr_dout_eop follows the same rule.
  - In IDLE, all lyr_dout_en and lyr_dout_eop bits are 0, and stray beats are dropped.
- lyr_dout is always dma_engineer_dout, combinationally.
- If a requester drops lyr_req before its ack, the arbiter still completes the transaction with the latched addr/length. This is a protocol violation and is not checked.
- While not in IDLE, new or other lyr_req bits are ignored; they are only evaluated on return to IDLE.
- Reset (synchronous, applies even mid-burst):
  - State goes to IDLE and rr_ptr and grant to 0.
  - dma_engineer_req, start_addr, length and err_len go to 0.
  - All lyr_* strobes are 0. In-flight beats after reset are dropped.

## Timing
- Request to dma_engineer_req: the req seen in IDLE at edge k gives dma_engineer_req high from edge k+1.
- Ack path: lyr_ack is the same cycle as dma_engineer_ack, with zero latency.
- Beat routing: dout_en/eop to lyr_dout_en/eop is zero latency (combinational mux).
- Back-to-back transactions: after the eop cycle, IDLE takes one cycle, then the next REQ follows. The minimum gap between transactions is 1 idle cycle.
- dma_engineer_start_addr and dma_engineer_length are registered, and held constant from REQ entry until the next grant.

## Configuration
- `DMA_ARB_LEN_CHECK_EN` defined:
  - An ADDR_W-bit beat counter clears on the IDLE→REQ transition.
  - It increments on each routed dout_en.
  - At eop, if (count+1) ≠ the latched length, err_len sets and stays set until rst.
- Undefined: no counter is built, and err_len is tied to 0.

## Test plan
- Single requester: lyr_req=4'b0100, addr=4548, length=4, ack 3 cycles after req, then 4 beats with eop on the 4th. Required response:
  - dma_engineer_start_addr=4548 and length=4.
  - lyr_ack[2] pulses once.
  - lyr_dout_en[2] pulses 4 times; all other layers see 0.
  - err_len=0.
- Round-robin: all four req high, each burst 2 beats. Required response: grant order 0,1,2,3,0, with exactly 1 idle cycle between eop and the next dma_engineer_req.
- Eop in the ack cycle: length=1, with ack, dout_en and eop all in the same cycle. Required response: return to IDLE on the next edge, and the next grant is issued 1 cycle later.
- Stray beat in IDLE: dout_en=1 with no grant. Required response: all lyr_dout_en=0 and the state stays IDLE.
- Reset mid-STREAM: assert rst after 2 of 4 beats. Required response:
  - All outputs are 0 and state is IDLE on the next edge.
  - Remaining beats are dropped.
  - A fresh req is granted starting from layer 0.
- With `DMA_ARB_LEN_CHECK_EN`: length=4 but eop arrives on the 3rd beat. Required response: err_len=1 from the cycle after eop, holding until rst. Without the macro, err_len stays 0.
